// File: rtl/stream_mux_n.sv
// stream_mux_n: N-channel, WIDTH-bit packet-aware stream multiplexer.
// Locks onto the requested channel for a whole packet and forwards its beats
// through a single registered output stage with a valid/ready handshake.
module stream_mux_n #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SELW-1:0]      sel,
    input  logic [N*WIDTH-1:0]   din,
    input  logic [N-1:0]         din_valid,
    input  logic [N-1:0]         din_last,
    output logic [N-1:0]         din_ready,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    output logic                 dout_last,
    input  logic                 dout_ready,
    output logic                 busy,
    output logic [SELW-1:0]      active_ch,
    output logic                 sel_err
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Valid vector padded to the full select range so sel >= N indexes a zero.
    localparam int              NP  = 1 << SELW;
    localparam logic [SELW:0]   N_L = (SELW + 1)'(N);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_dout;
    logic [WIDTH-1:0]       w_dout_nxt;
    logic                   r_dout_valid;
    logic                   w_dout_valid_nxt;
    logic                   r_dout_last;
    logic                   w_dout_last_nxt;
    logic                   r_busy;
    logic                   w_busy_nxt;
    logic [SELW-1:0]        r_active_ch;
    logic [SELW-1:0]        w_active_ch_nxt;
    logic                   r_sel_err;
    logic                   w_sel_err_nxt;

    logic [NP-1:0]          w_valid_ext;
    logic                   w_sel_ok;
    logic [WIDTH-1:0]       w_ch_data;
    logic                   w_ch_valid;
    logic                   w_ch_last;
    logic                   w_out_free;
    logic                   w_accept;

    assign w_valid_ext = NP'(din_valid);
    assign w_sel_ok    = ({1'b0, sel} < N_L);
    // Output register can take a new beat when empty or being drained.
    assign w_out_free  = !r_dout_valid || dout_ready;
    assign w_accept    = (r_state == ST_LOCKED) && w_ch_valid && w_out_free;

    // Pick the data, valid and last of the locked channel.
    always_comb begin
        w_ch_data  = {WIDTH{1'b0}};
        w_ch_valid = 1'b0;
        w_ch_last  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (r_active_ch == SELW'(k)) begin
                w_ch_data  = din[k*WIDTH +: WIDTH];
                w_ch_valid = din_valid[k];
                w_ch_last  = din_last[k];
            end else begin
                w_ch_data  = w_ch_data;
            end
        end
    end

    // Only the locked channel ever sees ready; everything else stays at 0.
    always_comb begin
        din_ready = {N{1'b0}};
        if (r_state == ST_LOCKED) begin
            for (int k = 0; k < N; k++) begin
                din_ready[k] = (r_active_ch == SELW'(k)) && w_out_free;
            end
        end else begin
            din_ready = {N{1'b0}};
        end
    end

    // Next-state logic: lock/unlock decisions and output-stage updates.
    always_comb begin
        w_state_nxt      = r_state;
        w_busy_nxt       = r_busy;
        w_active_ch_nxt  = r_active_ch;
        w_sel_err_nxt    = 1'b0;
        w_dout_nxt       = r_dout;
        w_dout_valid_nxt = r_dout_valid;
        w_dout_last_nxt  = r_dout_last;

        case (r_state)
            ST_IDLE: begin
                if (!w_sel_ok) begin
                    w_sel_err_nxt = 1'b1;
                end else if (w_valid_ext[sel]) begin
                    w_state_nxt     = ST_LOCKED;
                    w_active_ch_nxt = sel;
                    w_busy_nxt      = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (w_accept && w_ch_last) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // The last beat may still sit here after unlocking; it drains on dout_ready.
        if (w_accept) begin
            w_dout_nxt       = w_ch_data;
            w_dout_last_nxt  = w_ch_last;
            w_dout_valid_nxt = 1'b1;
        end else if (dout_ready) begin
            w_dout_valid_nxt = 1'b0;
        end else begin
            w_dout_valid_nxt = r_dout_valid;
        end
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_active_ch  <= {SELW{1'b0}};
            r_sel_err    <= 1'b0;
            r_dout       <= {WIDTH{1'b0}};
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= w_busy_nxt;
            r_active_ch  <= w_active_ch_nxt;
            r_sel_err    <= w_sel_err_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_dout_last  <= w_dout_last_nxt;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_last;
    assign busy       = r_busy;
    assign active_ch  = r_active_ch;
    assign sel_err    = r_sel_err;

endmodule

// File: tb/tb_stream_mux_n.sv
// Testbench for stream_mux_n: directed scenarios plus randomized packets,
// checked by a queue-based scoreboard fed from packet-level expectations.
module tb_stream_mux_n;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [SW-1:0]    sel;
    logic [N*W-1:0]   din;
    logic [N-1:0]     din_valid, din_last, din_ready;
    logic [W-1:0]     dout;
    logic             dout_valid, dout_last, dout_ready, busy, sel_err;
    logic [SW-1:0]    active_ch;

    // Second instance with a non-power-of-two channel count.
    logic [1:0]       sel3;
    logic [3*W-1:0]   din3;
    logic [2:0]       dv3, dl3, dr3;
    logic [W-1:0]     dout3;
    logic             dov3, dol3, dord3, busy3, serr3;
    logic [1:0]       ach3;

    stream_mux_n #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst(rst), .sel(sel), .din(din), .din_valid(din_valid),
        .din_last(din_last), .din_ready(din_ready), .dout(dout),
        .dout_valid(dout_valid), .dout_last(dout_last), .dout_ready(dout_ready),
        .busy(busy), .active_ch(active_ch), .sel_err(sel_err)
    );

    stream_mux_n #(.WIDTH(W), .N(3)) dut3 (
        .clk(clk), .rst(rst), .sel(sel3), .din(din3), .din_valid(dv3),
        .din_last(dl3), .din_ready(dr3), .dout(dout3),
        .dout_valid(dov3), .dout_last(dol3), .dout_ready(dord3),
        .busy(busy3), .active_ch(ach3), .sel_err(serr3)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [W:0] exp_q[$];
    logic [W:0] mon_e;
    int         cur_ch   = 0;
    bit         cons_rand = 1'b0;
    bit         cons_val  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_ch(input int k, input logic v, input logic l, input logic [W-1:0] d);
        din_valid[k]     = v;
        din_last[k]      = l;
        din[k*W +: W]    = d;
    endtask

    task automatic noise(input int ch);
        for (int k = 0; k < N; k++) begin
            if (k != ch) begin
                din_valid[k]  = 1'($urandom_range(0, 1));
                din_last[k]   = 1'($urandom_range(0, 1));
                din[k*W +: W] = 8'($urandom);
            end
        end
    endtask

    // Send one packet on channel ch, pushing its beats to the scoreboard first.
    task automatic send_pkt(input int ch, input int len);
        logic [W-1:0] beats[8];
        int           nb;
        int           guard;
        bit           is_last;
        cyc();
        cur_ch = ch;
        noise(ch);
        sel = SW'(ch);
        set_ch(ch, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < len; i++) begin
            beats[i] = 8'($urandom);
            exp_q.push_back({(i == len - 1), beats[i]});
        end
        for (int i = 0; i < len; i++) begin
            is_last = (i == len - 1);
            nb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
            repeat (nb) begin
                cyc();
                noise(ch);
                sel = (i == 0) ? SW'(ch) : SW'($urandom);
                set_ch(ch, 1'b0, 1'b0, 8'h00);
            end
            cyc();
            noise(ch);
            sel = (i == 0 || is_last) ? SW'(ch) : SW'($urandom);
            set_ch(ch, 1'b1, is_last, beats[i]);
            guard = 0;
            mid();
            while (!din_ready[ch]) begin
                guard++;
                if (guard > 100) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL handshake_timeout: ch %0d beat %0d never accepted", ch, i);
                    return;
                end
                cyc();
                noise(ch);
                mid();
            end
        end
    endtask

    // Consumer: drives dout_ready slightly after the driver's inputs settle.
    initial begin
        dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            dout_ready = cons_rand ? ($urandom_range(0, 3) != 0) : cons_val;
        end
    end

    // Monitor: pops and compares every beat the consumer takes.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("din_ready_scope", 32'(din_ready & ~(4'(1) << cur_ch)), 32'd0);
                if (dout_valid && dout_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got 0x%0h with nothing expected", {dout_last, dout});
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("beat", 32'({dout_last, dout}), 32'(mon_e));
                    end
                end
            end
        end
    end

    initial begin
        // Reset with every input active.
        rst = 1'b1; sel = 2'd2; din = {N{8'hA5}}; din_valid = '1; din_last = '1;
        sel3 = 2'd0; din3 = '0; dv3 = '0; dl3 = '0; dord3 = 1'b1;
        cons_val = 1'b1; cur_ch = 2;
        repeat (2) begin
            cyc(); mid();
            check("reset_outputs", 32'({dout, dout_valid, dout_last, din_ready, busy, active_ch, sel_err}), 32'd0);
        end
        cyc(); rst = 1'b0; mid();
        check("release_outputs", 32'({dout, dout_valid, dout_last, din_ready, busy, active_ch, sel_err}), 32'd0);
        cyc(); din_valid = '0; din_last = '0; rst = 1'b1;
        cyc(); rst = 1'b0;
        repeat (2) cyc();

        // Basic three-beat packet on channel 2.
        cur_ch = 2; sel = 2'd2; set_ch(2, 1'b1, 1'b0, 8'h11);
        exp_q.push_back(9'h011); exp_q.push_back(9'h022); exp_q.push_back(9'h133);
        mid(); check("basic_c0_busy", 32'(busy), 32'd0);
        cyc(); mid();
        check("basic_c1_busy", 32'(busy), 32'd1);
        check("basic_c1_ready", 32'(din_ready), 32'h4);
        check("basic_c1_dvalid", 32'(dout_valid), 32'd0);
        cyc(); set_ch(2, 1'b1, 1'b0, 8'h22); mid();
        check("basic_c2_out", 32'({dout_valid, dout_last, dout}), 32'({1'b1, 1'b0, 8'h11}));
        cyc(); set_ch(2, 1'b1, 1'b1, 8'h33); mid();
        check("basic_c3_out", 32'({dout_valid, dout_last, dout}), 32'({1'b1, 1'b0, 8'h22}));
        cyc(); set_ch(2, 1'b0, 1'b0, 8'h00); mid();
        check("basic_c4_out", 32'({dout_valid, dout_last, dout}), 32'({1'b1, 1'b1, 8'h33}));
        check("basic_c4_busy", 32'(busy), 32'd0);
        cyc(); mid();
        check("basic_c5_dvalid", 32'(dout_valid), 32'd0);

        // Backpressure: consumer stalls three cycles after the first beat.
        cyc(); set_ch(2, 1'b1, 1'b0, 8'h11);
        exp_q.push_back(9'h011); exp_q.push_back(9'h022); exp_q.push_back(9'h133);
        mid();
        cyc(); mid();
        cyc(); set_ch(2, 1'b1, 1'b0, 8'h22); cons_val = 1'b0; mid();
        check("bp_hold_out", 32'({dout_valid, dout_last, dout}), 32'({1'b1, 1'b0, 8'h11}));
        check("bp_hold_ready", 32'(din_ready), 32'd0);
        repeat (2) begin
            cyc(); mid();
            check("bp_hold_out", 32'({dout_valid, dout_last, dout}), 32'({1'b1, 1'b0, 8'h11}));
            check("bp_hold_ready", 32'(din_ready), 32'd0);
        end
        cyc(); cons_val = 1'b1; mid();
        check("bp_resume_ready", 32'(din_ready), 32'h4);
        cyc(); set_ch(2, 1'b1, 1'b1, 8'h33); mid();
        check("bp_c6_out", 32'({dout_valid, dout_last, dout}), 32'({1'b1, 1'b0, 8'h22}));
        cyc(); set_ch(2, 1'b0, 1'b0, 8'h00); mid();
        check("bp_c7_out", 32'({dout_valid, dout_last, dout}), 32'({1'b1, 1'b1, 8'h33}));
        check("bp_c7_busy", 32'(busy), 32'd0);
        cyc(); mid();

        // Select isolation: lock ch1, then request ch3 mid-packet.
        cyc(); cur_ch = 1; sel = 2'd1; set_ch(1, 1'b1, 1'b0, 8'hA1);
        exp_q.push_back(9'h0A1); exp_q.push_back(9'h0A2); exp_q.push_back(9'h1A3);
        mid();
        cyc(); sel = 2'd3; set_ch(3, 1'b1, 1'b1, 8'hB1); mid();
        check("iso_ready_c1", 32'(din_ready), 32'h2);
        check("iso_active_c1", 32'(active_ch), 32'd1);
        cyc(); set_ch(1, 1'b1, 1'b0, 8'hA2); mid();
        check("iso_ready_c2", 32'(din_ready), 32'h2);
        cyc(); set_ch(1, 1'b1, 1'b1, 8'hA3); mid();
        check("iso_ready3_c3", 32'(din_ready[3]), 32'd0);
        cyc(); set_ch(1, 1'b0, 1'b0, 8'h00); cur_ch = 3; exp_q.push_back(9'h1B1); mid();
        check("iso_c4_busy", 32'(busy), 32'd0);
        check("iso_c4_out", 32'({dout_valid, dout_last, dout}), 32'({1'b1, 1'b1, 8'hA3}));
        cyc(); mid();
        check("iso_c5_active", 32'(active_ch), 32'd3);
        check("iso_c5_ready", 32'(din_ready), 32'h8);
        cyc(); set_ch(3, 1'b0, 1'b0, 8'h00); mid();
        check("iso_c6_out", 32'({dout_valid, dout_last, dout}), 32'({1'b1, 1'b1, 8'hB1}));
        cyc(); mid();
        check("iso_active_hold", 32'({busy, active_ch}), 32'({1'b0, 2'd3}));

        // Out-of-range select on the three-channel instance.
        cyc(); sel3 = 2'd3; dv3 = 3'b111; din3 = {3{8'h5C}}; mid();
        check("oor_pre_err", 32'(serr3), 32'd0);
        cyc(); sel3 = 2'd0; dv3 = 3'b000; mid();
        check("oor_err_pulse", 32'(serr3), 32'd1);
        check("oor_busy", 32'(busy3), 32'd0);
        check("oor_ready", 32'(dr3), 32'd0);
        cyc(); mid();
        check("oor_err_clear", 32'({serr3, busy3}), 32'd0);
        cyc(); sel3 = 2'd2; dv3 = 3'b100; dl3 = 3'b100; din3[16 +: 8] = 8'h5A; mid();
        cyc(); mid();
        check("n3_lock_top", 32'({busy3, ach3, dr3}), 32'({1'b1, 2'd2, 3'b100}));
        cyc(); dv3 = 3'b000; mid();
        check("n3_out", 32'({dov3, dol3, dout3, busy3}), 32'({1'b1, 1'b1, 8'h5A, 1'b0}));

        // Mid-packet reset after the second of four beats.
        cyc(); cur_ch = 2; sel = 2'd2; set_ch(2, 1'b1, 1'b0, 8'hC1);
        exp_q.push_back(9'h0C1); exp_q.push_back(9'h0C2); exp_q.push_back(9'h0C3); exp_q.push_back(9'h1C4);
        mid();
        cyc(); mid();
        cyc(); set_ch(2, 1'b1, 1'b0, 8'hC2); mid();
        cyc(); set_ch(2, 1'b1, 1'b0, 8'hC3); rst = 1'b1; mid();
        cyc(); rst = 1'b0; set_ch(2, 1'b0, 1'b0, 8'h00); mid();
        check("mrst_cleared", 32'({dout_valid, busy, din_ready}), 32'd0);
        exp_q.delete();
        send_pkt(0, 3);

        // Randomized packets with noise and random backpressure.
        cons_rand = 1'b1;
        repeat (60) send_pkt($urandom_range(0, N - 1), $urandom_range(1, 6));
        cyc(); din_valid = '0; din_last = '0;
        cons_rand = 1'b0; cons_val = 1'b1;
        repeat (20) cyc();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
